// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, data-length codes and the
// baud rates the baud clock generator supports.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_START  = 3'd2,
    ST_DATA   = 3'd3,
    ST_PARITY = 3'd4,
    ST_STOP   = 3'd5
  } tx_state_t;

  localparam logic [1:0] LEN5 = 2'b00;
  localparam logic [1:0] LEN6 = 2'b01;
  localparam logic [1:0] LEN7 = 2'b10;
  localparam logic [1:0] LEN8 = 2'b11;

  localparam int unsigned BAUD_4800  = 4800;
  localparam int unsigned BAUD_9600  = 9600;
  localparam int unsigned BAUD_19200 = 19200;
  localparam int unsigned BAUD_38400 = 38400;
  localparam int unsigned BAUD_57600 = 57600;

  // Index of the last data bit (N-1) for a given length code.
  function automatic logic [2:0] last_bit_idx(input logic [1:0] len);
    case (len)
      LEN5:    return 3'd4;
      LEN6:    return 3'd5;
      LEN7:    return 3'd6;
      default: return 3'd7;
    endcase
  endfunction

endpackage

// File: rtl/baud_tick_det.sv
// Rising-edge detector for a baud square wave sampled on the system clock.
// The history register resets high so reset release never produces a tick.
module baud_tick_det (
  input  logic clk,
  input  logic rst,
  input  logic tx_clk_i,
  output logic tick_o
);

  logic tx_clk_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tx_clk_q <= 1'b1;
    else     tx_clk_q <= tx_clk_i;
  end

  assign tick_o = tx_clk_i & ~tx_clk_q;

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start, 5-8 data bits LSB first, optional parity,
// one or two stop bits, advancing one bit per rising edge of tx_clk.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tx_clk,
  input  logic          newd,
  input  logic [DW-1:0] tx_data,
  input  logic [1:0]    len,
  input  logic          parity_en,
  input  logic          parity_odd,
  input  logic          stop2,
  output logic          tx,
  output logic          busy,
  output logic          donetx,
  output tx_state_t     state_dbg
);

  tx_state_t     state_q, state_d;
  logic          tick;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [DW-1:0] shift_q, shift_d;
  logic [2:0]    count_q, count_d;
  logic [2:0]    last_q, last_d;
  logic          par_en_q, par_en_d;
  logic          par_q, par_d;
  logic          stop2_q, stop2_d;
  logic          stop_cnt_q, stop_cnt_d;
  logic          par_acc;

  baud_tick_det u_tick (
    .clk      (clk),
    .rst      (rst),
    .tx_clk_i (tx_clk),
    .tick_o   (tick)
  );

  // Parity is folded into one bit at acceptance so later data changes cannot leak in.
  always_comb begin
    par_acc = parity_odd;
    for (int i = 0; i < DW; i++) begin
      if (i <= int'(last_bit_idx(len))) par_acc = par_acc ^ tx_data[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (newd) state_d = ST_WAIT;
      ST_WAIT:   if (tick) state_d = ST_START;
      ST_START:  if (tick) state_d = ST_DATA;
      ST_DATA:   if (tick && !(count_q < last_q)) state_d = par_en_q ? ST_PARITY : ST_STOP;
      ST_PARITY: if (tick) state_d = ST_STOP;
      ST_STOP:   if (tick && (!stop2_q || stop_cnt_q)) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tx_d       = tx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    shift_d    = shift_q;
    count_d    = count_q;
    last_d     = last_q;
    par_en_d   = par_en_q;
    par_d      = par_q;
    stop2_d    = stop2_q;
    stop_cnt_d = stop_cnt_q;
    case (state_q)
      ST_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (newd) begin
          busy_d   = 1'b1;
          shift_d  = tx_data;
          last_d   = last_bit_idx(len);
          par_en_d = parity_en;
          par_d    = par_acc;
          stop2_d  = stop2;
        end
      end
      ST_WAIT: if (tick) tx_d = 1'b0;
      ST_START: begin
        if (tick) begin
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          count_d = 3'd0;
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (count_q < last_q) begin
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
            count_d = count_q + 3'd1;
          end else if (par_en_q) begin
            tx_d = par_q;
          end else begin
            tx_d       = 1'b1;
            stop_cnt_d = 1'b0;
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          tx_d       = 1'b1;
          stop_cnt_d = 1'b0;
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (stop2_q && !stop_cnt_q) begin
            stop_cnt_d = 1'b1;
          end else begin
            busy_d = 1'b0;
            done_d = 1'b1;
          end
        end
      end
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      shift_q    <= '0;
      count_q    <= 3'd0;
      last_q     <= 3'd0;
      par_en_q   <= 1'b0;
      par_q      <= 1'b0;
      stop2_q    <= 1'b0;
      stop_cnt_q <= 1'b0;
    end else begin
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      shift_q    <= shift_d;
      count_q    <= count_d;
      last_q     <= last_d;
      par_en_q   <= par_en_d;
      par_q      <= par_d;
      stop2_q    <= stop2_d;
      stop_cnt_q <= stop_cnt_d;
    end
  end

  assign tx        = tx_q;
  assign busy      = busy_q;
  assign donetx    = done_q;
  assign state_dbg = state_q;

endmodule
